// File: rtl/cache_req_sequencer.sv
// cache_req_sequencer: CPU-side front end for the three-level cache system.
// Queues read/write requests in a small FIFO, issues them one at a time,
// waits for completion (or times out), and reports data, latency and
// running statistics used for AMAT measurement.
module cache_req_sequencer #(
    parameter int ADDR_LENGTH = 15,
    parameter int DEPTH       = 4,
    parameter int LAT_W       = 16,
    parameter int TIMEOUT     = 8191
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic [ADDR_LENGTH-1:0] reqAddr,
    input  logic                   reqWrite,
    input  logic [31:0]            reqData,
    output logic [ADDR_LENGTH-1:0] addrIn,
    output logic                   enableIn,
    output logic                   writeIn,
    output logic [31:0]            dataIn,
    input  logic                   requestComplete,
    input  logic [31:0]            dataOut,
    output logic                   respValid,
    output logic [ADDR_LENGTH-1:0] respAddr,
    output logic                   respWrite,
    output logic [31:0]            respData,
    output logic [LAT_W-1:0]       respLatency,
    output logic                   respError,
    output logic [31:0]            reqCount,
    output logic [31:0]            cycleTotal,
    output logic                   busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(DEPTH);
    localparam logic [LAT_W-1:0] TIMEOUT_LAT = LAT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateType;

    logic [ADDR_LENGTH-1:0] fifoAddr  [DEPTH];
    logic                   fifoWrite [DEPTH];
    logic [31:0]            fifoData  [DEPTH];
    logic [PTR_W-1:0]       wrPtrQ, rdPtrQ;
    logic [CNT_W-1:0]       countQ;

    stateType               stateQ, stateD;
    logic [ADDR_LENGTH-1:0] addrQ, addrD;
    logic                   writeQ, writeD;
    logic [31:0]            dataQ, dataD;
    logic                   enableQ, enableD;
    logic [LAT_W-1:0]       latQ, latD;
    logic                   respValidQ, respValidD;
    logic [ADDR_LENGTH-1:0] respAddrQ, respAddrD;
    logic                   respWriteQ, respWriteD;
    logic [31:0]            respDataQ, respDataD;
    logic [LAT_W-1:0]       respLatencyQ, respLatencyD;
    logic                   respErrorQ, respErrorD;
    logic [31:0]            reqCountQ, reqCountD;
    logic [31:0]            cycleTotalQ, cycleTotalD;

    logic                   full;
    logic                   push;
    logic                   pop;
    logic [32:0]            totalSum;

    // Acceptance depends only on fullness, so a pop cannot make room for a same-cycle push.
    assign full     = (countQ == FULL_COUNT);
    assign push     = reqValid && !full;
    assign pop      = (stateQ == IDLE) && (countQ != '0);
    assign totalSum = {1'b0, cycleTotalQ} + 33'(latQ);

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clock) begin
        if (push) begin
            fifoAddr[wrPtrQ]  <= reqAddr;
            fifoWrite[wrPtrQ] <= reqWrite;
            fifoData[wrPtrQ]  <= reqData;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (push) wrPtrQ <= wrPtrQ + PTR_W'(1);
            if (pop)  rdPtrQ <= rdPtrQ + PTR_W'(1);
            if (push && !pop)      countQ <= countQ + CNT_W'(1);
            else if (!push && pop) countQ <= countQ - CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    // Next state, issue/hold of the cache request, and response/statistics updates.
    always_comb begin
        stateD       = stateQ;
        addrD        = addrQ;
        writeD       = writeQ;
        dataD        = dataQ;
        enableD      = enableQ;
        latD         = latQ;
        respValidD   = 1'b0;
        respAddrD    = respAddrQ;
        respWriteD   = respWriteQ;
        respDataD    = respDataQ;
        respLatencyD = respLatencyQ;
        respErrorD   = respErrorQ;
        reqCountD    = reqCountQ;
        cycleTotalD  = cycleTotalQ;
        case (stateQ)
            IDLE: begin
                if (pop) begin
                    stateD  = BUSY;
                    addrD   = fifoAddr[rdPtrQ];
                    writeD  = fifoWrite[rdPtrQ];
                    dataD   = fifoData[rdPtrQ];
                    enableD = 1'b1;
                    latD    = LAT_W'(1);
                end
            end
            BUSY: begin
                if (requestComplete || (latQ == TIMEOUT_LAT)) begin
                    stateD       = DONE;
                    enableD      = 1'b0;
                    respValidD   = 1'b1;
                    respAddrD    = addrQ;
                    respWriteD   = writeQ;
                    respErrorD   = !requestComplete;
                    respDataD    = (requestComplete && !writeQ) ? dataOut : 32'd0;
                    respLatencyD = latQ;
                    reqCountD    = (reqCountQ == 32'hFFFF_FFFF) ? reqCountQ : reqCountQ + 32'd1;
                    cycleTotalD  = totalSum[32] ? 32'hFFFF_FFFF : totalSum[31:0];
                end else begin
                    latD = latQ + LAT_W'(1);
                end
            end
            DONE: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addrQ        <= '0;
            writeQ       <= 1'b0;
            dataQ        <= '0;
            enableQ      <= 1'b0;
            latQ         <= '0;
            respValidQ   <= 1'b0;
            respAddrQ    <= '0;
            respWriteQ   <= 1'b0;
            respDataQ    <= '0;
            respLatencyQ <= '0;
            respErrorQ   <= 1'b0;
            reqCountQ    <= '0;
            cycleTotalQ  <= '0;
        end else begin
            addrQ        <= addrD;
            writeQ       <= writeD;
            dataQ        <= dataD;
            enableQ      <= enableD;
            latQ         <= latD;
            respValidQ   <= respValidD;
            respAddrQ    <= respAddrD;
            respWriteQ   <= respWriteD;
            respDataQ    <= respDataD;
            respLatencyQ <= respLatencyD;
            respErrorQ   <= respErrorD;
            reqCountQ    <= reqCountD;
            cycleTotalQ  <= cycleTotalD;
        end
    end

    assign reqReady    = !full;
    assign addrIn      = addrQ;
    assign enableIn    = enableQ;
    assign writeIn     = writeQ;
    assign dataIn      = dataQ;
    assign respValid   = respValidQ;
    assign respAddr    = respAddrQ;
    assign respWrite   = respWriteQ;
    assign respData    = respDataQ;
    assign respLatency = respLatencyQ;
    assign respError   = respErrorQ;
    assign reqCount    = reqCountQ;
    assign cycleTotal  = cycleTotalQ;
    assign busy        = (stateQ != IDLE);

endmodule
